data_mem_peri_timers: RTL and testbench
=======================================

Name: data_mem_peri_timers

Overview:
Word-addressed data memory plus a memory-mapped peripheral region for the single-cycle/pipelined MIPS core.
- RAM accesses support byte enables.
- Peripheral region carries NUM_TIMERS independent reload timers with interrupt flags, an LED register, a digit-display register and a read-only system clock counter.
- Sits on the core's MEM stage; irq lines go to the core's exception logic.

Parameters:
- RAM_WORDS, 512, RAM depth in 32-bit words.
- RAM_ADDR_BITS, 9, log2(RAM_WORDS); RAM index = Address[RAM_ADDR_BITS+1:2].
- NUM_TIMERS, 2, timer channels, legal range 1..8.
- PERI_TAG, 4'h4, value of Address[31:28] that selects the peripheral region.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- clk_count  in  32  system cycle counter, exposed read-only.
- Address  in  32  byte address; Address[1:0] ignored.
- Write_data  in  32  store data.
- Byte_en  in  4  lane enables; Byte_en[k] covers bits [8k+7:8k].
- MemRead  in  1  load strobe.
- MemWrite  in  1  store strobe.
- Read_data  out  32  registered load data.
- leds  out  32  LED register.
- digits  out  32  digit-display register.
- irq  out  NUM_TIMERS  per-timer interrupt flag.

Behaviour:
Reset:
- Read_data, leds, digits, all timer TH/TL/TCON and irq are 0 on the edge where reset=1.
- RAM contents are not cleared; they are undefined until written.
- Reset overrides any same-cycle access or timer event.

Region decode:
- peri = (Address[31:28]==PERI_TAG). Otherwise the access goes to RAM, index wraps modulo RAM_WORDS.
- Peripheral offset = Address[11:0]; Address[27:12] is ignored (aliased).
- Peripheral map:
  - Timer i at 0x10*i: +0x0 TH (reload), +0x4 TL (counter), +0x8 TCON.
  - 0x080 leds, 0x084 digits, 0x088 sysclk (read-only).
- TCON bits: [0] enable, [1] int_en, [2] flag; bits [31:3] read 0.
- Unmapped offsets, and timers i>=NUM_TIMERS: read 0, writes ignored.

Read:
- One-cycle latency. On posedge, Read_data <= MemRead ? selected word : 0.
- A sysclk read returns clk_count present at that edge.
- Read-during-write to the same RAM word returns the old contents.

Write:
- RAM: each lane with Byte_en[k]=1 is written; Byte_en=0 means no write.
- Peripheral: full-word write when MemWrite=1 and Byte_en!=0; Byte_en pattern otherwise ignored.
- Writes to sysclk are ignored.

Timer channel, each posedge, not in reset:
- CPU write to TL that cycle: TL <= Write_data; no count.
- Else if enable=1 and TL==32'hFFFFFFFF: TL <= TH; flag <= flag | int_en.
- Else if enable=1: TL <= TL+1.
- Enable=0: TL holds.
- CPU write to TCON: enable, int_en and flag take Write_data[2:0]. If an overflow with int_en occurs the same cycle, flag=1 (set wins).
- A CPU write to TH takes effect for reloads from the next edge onward.
- irq[i] = flag of timer i (registered, no extra latency).

Decomposition:
- Package data_mem_pkg holds the offset constants (TIMER_STRIDE=0x10, OFF_TH/OFF_TL/OFF_TCON, OFF_LEDS=0x080, OFF_DIGITS=0x084, OFF_SYSCLK=0x088) and TCON bit indices.
- One sub-module, timer_channel: ports clk, reset, wr_th, wr_tl, wr_tcon, wdata, th, tl, tcon, irq. Instantiated NUM_TIMERS times via generate.
- Top level holds the RAM array, address decode, read mux, leds and digits.

Test Plan:
1. Write 0x12345678 to 0x0000_0010 with Byte_en=4'hF, then 0xAABBCCDD with Byte_en=4'b0010, then read 0x10 -> Read_data=0x1234CC78 one cycle after the MemRead edge.
2. Timer 0: TH=TL=0xFFFFFFFC, TCON=3 -> TL reads FD, FE, FF on successive cycles, then FC; flag and irq[0] rise on the same edge TL reloads; TCON reads 0x7.
3. Overflow edge coincides with a write of TCON=3 (flag clear) -> flag stays 1. On the following edge, a write of TCON=3 with no overflow -> irq[0]=0.
4. Timer 1 runs with TCON=1 (int_en=0) through overflow -> TL reloads, irq[1] stays 0, timer 0 state unchanged.
5. Assert reset while timer 0 is counting and MemRead=1 -> next edge TL=0, TCON=0, irq=0, Read_data=0, leds=0; RAM word at 0x10 still reads 0x1234CC78 afterwards.
6. Read 0x4000_0200 -> 0. Read 0x4000_0088 -> the clk_count value at that edge. MemRead=0 -> Read_data=0. Write to 0x4000_0088 -> no effect.

Source files
------------

// File: rtl/data_mem_peri_timers_pkg.sv
// Shared constants for the data memory / peripheral block: peripheral
// offsets inside the 4 KB peripheral window and TCON bit positions.
package data_mem_pkg;

    localparam int          MAX_TIMERS   = 8;
    localparam logic [11:0] TIMER_STRIDE = 12'h010;

    localparam logic [3:0]  OFF_TH       = 4'h0;
    localparam logic [3:0]  OFF_TL       = 4'h4;
    localparam logic [3:0]  OFF_TCON     = 4'h8;

    localparam logic [11:0] OFF_LEDS     = 12'h080;
    localparam logic [11:0] OFF_DIGITS   = 12'h084;
    localparam logic [11:0] OFF_SYSCLK   = 12'h088;

    localparam int          TCON_EN      = 0;
    localparam int          TCON_IE      = 1;
    localparam int          TCON_FLAG    = 2;

endpackage

// File: rtl/data_mem_peri_timers_if.sv
// MEM-stage bus between the core (master) and the data memory (slave).
interface data_mem_peri_timers_if;

    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [3:0]  Byte_en;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;

    modport master (
        output Address, Write_data, Byte_en, MemRead, MemWrite,
        input  Read_data
    );

    modport slave (
        input  Address, Write_data, Byte_en, MemRead, MemWrite,
        output Read_data
    );

endinterface

// File: rtl/data_mem_peri_timers_timer_channel.sv
// One reload timer: TL counts up while enabled, reloads from TH after
// 0xFFFFFFFF and latches an interrupt flag when int_en is set.
module timer_channel
    import data_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [31:0] tcon,
    output logic        irq
);

    logic [31:0] th_r;
    logic [31:0] tl_r;
    logic        en_r;
    logic        ie_r;
    logic        flag_r;
    logic        ovf_s;
    logic        flag_set_s;

    // Overflow is suppressed by a same-cycle CPU write to TL.
    always_comb begin
        ovf_s      = 1'b0;
        flag_set_s = 1'b0;
        if (en_r && !wr_tl && (tl_r == 32'hFFFF_FFFF)) begin
            ovf_s      = 1'b1;
            flag_set_s = ie_r;
        end else begin
            ovf_s      = 1'b0;
            flag_set_s = 1'b0;
        end
    end

    // Counter, reload and control register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_r   <= 32'd0;
            tl_r   <= 32'd0;
            en_r   <= 1'b0;
            ie_r   <= 1'b0;
            flag_r <= 1'b0;
        end else begin
            if (wr_th) begin
                th_r <= wdata;
            end
            if (wr_tl) begin
                tl_r <= wdata;
            end else if (ovf_s) begin
                tl_r <= th_r;
            end else if (en_r) begin
                tl_r <= tl_r + 32'd1;
            end
            // A flag set from overflow beats a CPU clear in the same cycle.
            if (wr_tcon) begin
                en_r   <= wdata[TCON_EN];
                ie_r   <= wdata[TCON_IE];
                flag_r <= wdata[TCON_FLAG] | flag_set_s;
            end else begin
                flag_r <= flag_r | flag_set_s;
            end
        end
    end

    assign th   = th_r;
    assign tl   = tl_r;
    assign tcon = {29'd0, flag_r, ie_r, en_r};
    assign irq  = flag_r;

endmodule

// File: rtl/data_mem_peri_timers.sv
// Word-addressed data RAM with byte enables plus a peripheral window holding
// reload timers, LED and digit registers and a read-only cycle counter.
module data_mem_peri_timers
    import data_mem_pkg::*;
#(
    parameter int          RAM_WORDS     = 512,
    parameter int          RAM_ADDR_BITS = 9,
    parameter int          NUM_TIMERS    = 2,
    parameter logic [3:0]  PERI_TAG      = 4'h4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           clk_count,
    data_mem_peri_timers_if.slave bus,
    output logic [31:0]           leds,
    output logic [31:0]           digits,
    output logic [NUM_TIMERS-1:0] irq
);

    logic [31:0]              ram_r [RAM_WORDS];
    logic [31:0]              read_data_r;
    logic [31:0]              leds_r;
    logic [31:0]              digits_r;

    logic                     peri_s;
    logic [11:0]              off_s;
    logic [RAM_ADDR_BITS-1:0] ram_idx_s;
    logic [2:0]               tsel_s;
    logic [3:0]               treg_s;
    logic                     timer_hit_s;
    logic                     wr_peri_s;
    logic                     wr_timer_s;
    logic                     ram_wr_s;
    logic [31:0]              rd_peri_s;
    logic                     unused_s;

    logic [31:0]              th_s   [MAX_TIMERS];
    logic [31:0]              tl_s   [MAX_TIMERS];
    logic [31:0]              tcon_s [MAX_TIMERS];

    // Offset bits [27:12] alias the window and [1:0] are byte-in-word.
    assign peri_s      = (bus.Address[31:28] == PERI_TAG);
    assign off_s       = {bus.Address[11:2], 2'b00};
    assign ram_idx_s   = bus.Address[RAM_ADDR_BITS+1:2];
    assign tsel_s      = off_s[6:4];
    assign treg_s      = off_s[3:0];
    assign timer_hit_s = (off_s[11:7] == 5'd0) && ({1'b0, tsel_s} < 4'(NUM_TIMERS));
    assign wr_peri_s   = bus.MemWrite && peri_s && (bus.Byte_en != 4'd0);
    assign wr_timer_s  = wr_peri_s && timer_hit_s;
    assign ram_wr_s    = bus.MemWrite && !peri_s && !reset;
    assign unused_s    = ^{bus.Address[27:12], bus.Address[1:0]};

    for (genvar i = 0; i < MAX_TIMERS; i++) begin : g_tmr
        if (i < NUM_TIMERS) begin : g_on
            logic wr_th_s;
            logic wr_tl_s;
            logic wr_tcon_s;

            assign wr_th_s   = wr_timer_s && (tsel_s == 3'(i)) && (treg_s == OFF_TH);
            assign wr_tl_s   = wr_timer_s && (tsel_s == 3'(i)) && (treg_s == OFF_TL);
            assign wr_tcon_s = wr_timer_s && (tsel_s == 3'(i)) && (treg_s == OFF_TCON);

            timer_channel u_timer (
                .clk     (clk),
                .reset   (reset),
                .wr_th   (wr_th_s),
                .wr_tl   (wr_tl_s),
                .wr_tcon (wr_tcon_s),
                .wdata   (bus.Write_data),
                .th      (th_s[i]),
                .tl      (tl_s[i]),
                .tcon    (tcon_s[i]),
                .irq     (irq[i])
            );
        end else begin : g_off
            assign th_s[i]   = 32'd0;
            assign tl_s[i]   = 32'd0;
            assign tcon_s[i] = 32'd0;
        end
    end

    // Peripheral read mux; unmapped offsets return zero.
    always_comb begin
        rd_peri_s = 32'd0;
        if (timer_hit_s) begin
            case (treg_s)
                OFF_TH:   rd_peri_s = th_s[tsel_s];
                OFF_TL:   rd_peri_s = tl_s[tsel_s];
                OFF_TCON: rd_peri_s = tcon_s[tsel_s];
                default:  rd_peri_s = 32'd0;
            endcase
        end else begin
            case (off_s)
                OFF_LEDS:   rd_peri_s = leds_r;
                OFF_DIGITS: rd_peri_s = digits_r;
                OFF_SYSCLK: rd_peri_s = clk_count;
                default:    rd_peri_s = 32'd0;
            endcase
        end
    end

    // RAM byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.Byte_en[k]) begin
                    ram_r[ram_idx_s][8*k +: 8] <= bus.Write_data[8*k +: 8];
                end
            end
        end
    end

    // Registered load data and the LED / digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_r <= 32'd0;
            leds_r      <= 32'd0;
            digits_r    <= 32'd0;
        end else begin
            if (bus.MemRead) begin
                read_data_r <= peri_s ? rd_peri_s : ram_r[ram_idx_s];
            end else begin
                read_data_r <= 32'd0;
            end
            if (wr_peri_s && (off_s == OFF_LEDS)) begin
                leds_r <= bus.Write_data;
            end
            if (wr_peri_s && (off_s == OFF_DIGITS)) begin
                digits_r <= bus.Write_data;
            end
        end
    end

    assign bus.Read_data = read_data_r;
    assign leds          = leds_r;
    assign digits        = digits_r;

endmodule

// File: tb/tb_data_mem_peri_timers.sv
// Directed bench for data_mem_peri_timers: RAM byte lanes, timer reload and
// flag priority, reset, and peripheral decode corner cases.
module tb_data_mem_peri_timers;

    logic        clk;
    logic        reset;
    logic [31:0] clk_count;
    logic [31:0] leds;
    logic [31:0] digits;
    logic [1:0]  irq;
    int          checks;
    int          errors;

    data_mem_peri_timers_if bus ();

    data_mem_peri_timers #(
        .RAM_WORDS     (512),
        .RAM_ADDR_BITS (9),
        .NUM_TIMERS    (2),
        .PERI_TAG      (4'h4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_count (clk_count),
        .bus       (bus),
        .leds      (leds),
        .digits    (digits),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.Address    = a;
        bus.Write_data = d;
        bus.Byte_en    = be;
        bus.MemWrite   = 1'b1;
        cycle();
        bus.MemWrite   = 1'b0;
        bus.Byte_en    = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        bus.Address = a;
        bus.MemRead = 1'b1;
        cycle();
        bus.MemRead = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        checks++;
        if (bus.Read_data !== 32'd0 || leds !== 32'd0 || digits !== 32'd0 || irq !== 2'b00) begin
            errors++;
            $display("FAIL reset_state rd=%h leds=%h digits=%h irq=%b required all 0",
                     bus.Read_data, leds, digits, irq);
        end
    endtask

    task automatic test_ram_bytes();
        bus_write(32'h0000_0010, 32'h1234_5678, 4'hF);
        bus_write(32'h0000_0010, 32'hAABB_CCDD, 4'b0010);
        bus_write(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
        bus_read(32'h0000_0010);
        checks++;
        if (bus.Read_data !== 32'h1234_CC78) begin
            errors++;
            $display("FAIL ram_byte_en got %h required %h", bus.Read_data, 32'h1234_CC78);
        end
        // 0x814 wraps to word 5, the same word as 0x14.
        bus_write(32'h0000_0814, 32'h0BAD_F00D, 4'hF);
        bus_read(32'h0000_0014);
        checks++;
        if (bus.Read_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL ram_wrap got %h required %h", bus.Read_data, 32'h0BAD_F00D);
        end
        // Read-during-write sees the old word.
        bus.Address    = 32'h0000_0014;
        bus.Write_data = 32'h0000_0000;
        bus.Byte_en    = 4'hF;
        bus.MemWrite   = 1'b1;
        bus.MemRead    = 1'b1;
        cycle();
        bus.MemWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.Byte_en    = 4'd0;
        checks++;
        if (bus.Read_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rdw_old got %h required %h", bus.Read_data, 32'h0BAD_F00D);
        end
        bus_read(32'h0000_0014);
        checks++;
        if (bus.Read_data !== 32'h0000_0000) begin
            errors++;
            $display("FAIL rdw_new got %h required %h", bus.Read_data, 32'h0000_0000);
        end
    endtask

    task automatic test_timer_reload();
        logic [31:0] exp_tl  [5];
        logic        exp_irq [5];
        exp_tl  = '{32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus_write(32'h4000_0000, 32'hFFFF_FFFC, 4'hF);
        bus_write(32'h4000_0004, 32'hFFFF_FFFC, 4'hF);
        bus_write(32'h4000_0008, 32'h0000_0003, 4'hF);
        // Each read returns TL as it was before that edge's increment.
        for (int n = 0; n < 5; n++) begin
            bus_read(32'h4000_0004);
            checks++;
            if (bus.Read_data !== exp_tl[n] || irq[0] !== exp_irq[n]) begin
                errors++;
                $display("FAIL tl_seq[%0d] tl=%h irq0=%b required tl=%h irq0=%b",
                         n, bus.Read_data, irq[0], exp_tl[n], exp_irq[n]);
            end
        end
        bus_read(32'h4000_0008);
        checks++;
        if (bus.Read_data !== 32'h0000_0007) begin
            errors++;
            $display("FAIL tcon_flag got %h required %h", bus.Read_data, 32'h0000_0007);
        end
    endtask

    task automatic test_flag_priority();
        // TL is FE here; it reaches FF on this idle edge.
        cycle();
        bus_write(32'h4000_0008, 32'h0000_0003, 4'hF);
        checks++;
        if (irq[0] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins irq0=%b required 1", irq[0]);
        end
        bus_write(32'h4000_0008, 32'h0000_0003, 4'hF);
        checks++;
        if (irq[0] !== 1'b0) begin
            errors++;
            $display("FAIL flag_clear irq0=%b required 0", irq[0]);
        end
        bus_read(32'h4000_0004);
        checks++;
        if (bus.Read_data !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL tl_after_reload got %h required %h", bus.Read_data, 32'hFFFF_FFFD);
        end
    endtask

    task automatic test_timer1_no_int();
        // Stopping timer 0 lets its last increment land: FE -> FF.
        bus_write(32'h4000_0008, 32'h0000_0000, 4'hF);
        bus_write(32'h4000_0010, 32'h0000_0100, 4'hF);
        bus_write(32'h4000_0014, 32'hFFFF_FFFE, 4'hF);
        bus_write(32'h4000_0018, 32'h0000_0001, 4'hF);
        cycle();
        cycle();
        cycle();
        checks++;
        if (irq !== 2'b00) begin
            errors++;
            $display("FAIL t1_irq irq=%b required 00", irq);
        end
        bus_read(32'h4000_0014);
        checks++;
        if (bus.Read_data !== 32'h0000_0101) begin
            errors++;
            $display("FAIL t1_reload got %h required %h", bus.Read_data, 32'h0000_0101);
        end
        bus_read(32'h4000_0018);
        checks++;
        if (bus.Read_data !== 32'h0000_0001) begin
            errors++;
            $display("FAIL t1_tcon got %h required %h", bus.Read_data, 32'h0000_0001);
        end
        bus_read(32'h4000_0004);
        checks++;
        if (bus.Read_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL t0_hold_tl got %h required %h", bus.Read_data, 32'hFFFF_FFFF);
        end
        bus_read(32'h4000_0008);
        checks++;
        if (bus.Read_data !== 32'h0000_0000) begin
            errors++;
            $display("FAIL t0_hold_tcon got %h required %h", bus.Read_data, 32'h0000_0000);
        end
    endtask

    task automatic test_reset_midrun();
        // Enable at FF: next edge overflows into FC with the flag set.
        bus_write(32'h4000_0008, 32'h0000_0003, 4'hF);
        bus_write(32'h4000_0080, 32'h0000_0055, 4'hF);
        bus_write(32'h4000_0084, 32'h0000_1234, 4'h1);
        checks++;
        if (leds !== 32'h0000_0055 || digits !== 32'h0000_1234 || irq[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset leds=%h digits=%h irq0=%b required 55 1234 1",
                     leds, digits, irq[0]);
        end
        reset          = 1'b1;
        bus.Address    = 32'h0000_0010;
        bus.MemRead    = 1'b1;
        cycle();
        reset          = 1'b0;
        bus.MemRead    = 1'b0;
        checks++;
        if (bus.Read_data !== 32'd0 || leds !== 32'd0 || digits !== 32'd0 || irq !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset rd=%h leds=%h digits=%h irq=%b required all 0",
                     bus.Read_data, leds, digits, irq);
        end
        bus_read(32'h4000_0004);
        checks++;
        if (bus.Read_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_tl got %h required 0", bus.Read_data);
        end
        bus_read(32'h4000_0008);
        checks++;
        if (bus.Read_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_tcon got %h required 0", bus.Read_data);
        end
        bus_read(32'h0000_0010);
        checks++;
        if (bus.Read_data !== 32'h1234_CC78) begin
            errors++;
            $display("FAIL ram_kept got %h required %h", bus.Read_data, 32'h1234_CC78);
        end
    endtask

    task automatic test_peri_decode();
        bus_read(32'h4000_0200);
        checks++;
        if (bus.Read_data !== 32'd0) begin
            errors++;
            $display("FAIL unmapped got %h required 0", bus.Read_data);
        end
        clk_count = 32'hCAFE_F00D;
        bus_read(32'h4000_0088);
        checks++;
        if (bus.Read_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL sysclk got %h required %h", bus.Read_data, 32'hCAFE_F00D);
        end
        bus.Address = 32'h4000_0088;
        cycle();
        checks++;
        if (bus.Read_data !== 32'd0) begin
            errors++;
            $display("FAIL no_read got %h required 0", bus.Read_data);
        end
        bus_write(32'h4000_0088, 32'h0000_DEAD, 4'hF);
        clk_count = 32'h0000_0011;
        bus_read(32'h4000_0088);
        checks++;
        if (bus.Read_data !== 32'h0000_0011) begin
            errors++;
            $display("FAIL sysclk_ro got %h required %h", bus.Read_data, 32'h0000_0011);
        end
        // Aliased window address, then a zero-enable write that must be ignored.
        bus_write(32'h4123_4080, 32'h0000_00A5, 4'h8);
        bus_write(32'h4000_0080, 32'h0000_0077, 4'h0);
        checks++;
        if (leds !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL leds_alias got %h required %h", leds, 32'h0000_00A5);
        end
        bus_write(32'h4000_0024, 32'h0000_0042, 4'hF);
        bus_read(32'h4000_0024);
        checks++;
        if (bus.Read_data !== 32'd0) begin
            errors++;
            $display("FAIL timer2_absent got %h required 0", bus.Read_data);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        clk_count      = 32'd0;
        bus.Address    = 32'd0;
        bus.Write_data = 32'd0;
        bus.Byte_en    = 4'd0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        test_reset();
        test_ram_bytes();
        test_timer_reload();
        test_flag_priority();
        test_timer1_no_int();
        test_reset_midrun();
        test_peri_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
